// File: rtl/multibyte_add_seq_if.sv
// Request/response bundle between a requesting unit and the
// byte-serial multi-precision adder.
interface multibyte_add_seq_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         c_out;
    logic         ovf;

    modport master (
        output start, a, b, c_in, sub,
        input  busy, done, s, c_out, ovf
    );

    modport slave (
        input  start, a, b, c_in, sub,
        output busy, done, s, c_out, ovf
    );
endinterface

// File: rtl/multibyte_add_seq.sv
// Byte-serial multi-precision add/sub: one 8-bit ripple adder reused
// LSB-first with a registered carry between bytes.
module _8bit_rca (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c_in,
    output logic [7:0] s,
    output logic       c_out
);
    logic [8:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[8];
endmodule

module multibyte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    multibyte_add_seq_if.slave  bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   s_q;
    logic [IW-1:0]  idx;
    logic           carry_q;
    logic           c_out_q;
    logic           ovf_q;
    logic [7:0]     a_byte;
    logic [7:0]     b_byte;
    logic [7:0]     sum;
    logic           rca_co;
    logic           last;

    assign a_byte = a_q[8*idx +: 8];
    assign b_byte = b_q[8*idx +: 8];
    assign last   = (idx == IW'(NBYTES - 1));

    _8bit_rca u_rca (
        .a     (a_byte),
        .b     (b_byte),
        .c_in  (carry_q),
        .s     (sum),
        .c_out (rca_co)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx     <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub | bus.c_in;
                        idx     <= '0;
                        s_q     <= '0;
                    end
                end
                RUN: begin
                    s_q[8*idx +: 8] <= sum;
                    carry_q         <= rca_co;
                    idx             <= idx + 1'b1;
                    // Final byte holds the sign bits of both operands
                    if (last) begin
                        c_out_q <= rca_co;
                        ovf_q   <= (a_byte[7] == b_byte[7]) &&
                                   (sum[7] != a_byte[7]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.s     = s_q;
    assign bus.c_out = c_out_q;
    assign bus.ovf   = ovf_q;
endmodule
